// File: rtl/phy_pkg.sv
// Shared constants and types for the PHY receive lane demultiplexer.
package phy_pkg;

   localparam logic [7:0] COM_SYMBOL_DEF  = 8'hBC;
   localparam int         ALIGN_COUNT_DEF = 4;
   localparam int         NUM_LANES       = 4;
   localparam int         LANE_PTR_W      = 2;

   typedef enum logic {
      ALIGN  = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // Saturating 8-bit increment used by the misalignment counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] result;
      if (value == 8'hFF) begin
         result = 8'hFF;
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/phy_rx_demux_if.sv
// Byte-stream input and four-lane output bundle of phy_rx_demux.
// err_count exists only when PHY_RX_ERRCNT_EN is defined.
interface phy_rx_demux_if;

   logic [7:0] data_in;
   logic       valid_in;
   logic [7:0] data_out0;
   logic [7:0] data_out1;
   logic [7:0] data_out2;
   logic [7:0] data_out3;
   logic       valid_out0;
   logic       valid_out1;
   logic       valid_out2;
   logic       valid_out3;
   logic       aligned;
`ifdef PHY_RX_ERRCNT_EN
   logic [7:0] err_count;

   modport master (
      output data_in, valid_in,
      input  data_out0, data_out1, data_out2, data_out3,
      input  valid_out0, valid_out1, valid_out2, valid_out3,
      input  aligned, err_count
   );

   modport slave (
      input  data_in, valid_in,
      output data_out0, data_out1, data_out2, data_out3,
      output valid_out0, valid_out1, valid_out2, valid_out3,
      output aligned, err_count
   );
`else
   modport master (
      output data_in, valid_in,
      input  data_out0, data_out1, data_out2, data_out3,
      input  valid_out0, valid_out1, valid_out2, valid_out3,
      input  aligned
   );

   modport slave (
      input  data_in, valid_in,
      output data_out0, data_out1, data_out2, data_out3,
      output valid_out0, valid_out1, valid_out2, valid_out3,
      output aligned
   );
`endif

endinterface

// File: rtl/phy_rx_aligner.sv
// COM detection and ALIGN/ACTIVE lock FSM; produces the lock flag plus
// per-byte accept and misalignment strobes for the lane logic.
module phy_rx_aligner
   import phy_pkg::*;
#(
   parameter logic [7:0] COM_SYMBOL  = COM_SYMBOL_DEF,
   parameter int         ALIGN_COUNT = ALIGN_COUNT_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            data_in,
   input  logic                  valid_in,
   input  logic [LANE_PTR_W-1:0] lane_ptr,
   output logic                  aligned,
   output logic                  misalign,
   output logic                  accept
);

   state_t     state_r;
   state_t     state_s;
   logic [3:0] com_cnt_r;
   logic [3:0] com_cnt_s;
   logic [4:0] cnt_inc_s;
   logic       is_com_s;
   logic       misalign_s;
   logic       accept_s;

   assign is_com_s  = (data_in == COM_SYMBOL);
   assign cnt_inc_s = {1'b0, com_cnt_r} + 5'd1;

   // State and COM run counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ALIGN;
         com_cnt_r <= 4'd0;
      end else begin
         state_r   <= state_s;
         com_cnt_r <= com_cnt_s;
      end
   end

   // Next-state, COM run count and byte strobes; idle cycles change nothing.
   always_comb begin
      state_s    = state_r;
      com_cnt_s  = com_cnt_r;
      misalign_s = 1'b0;
      accept_s   = 1'b0;
      if (valid_in) begin
         case (state_r)
            ALIGN: begin
               if (is_com_s) begin
                  if (cnt_inc_s >= 5'(ALIGN_COUNT)) begin
                     state_s   = ACTIVE;
                     com_cnt_s = 4'd0;
                  end else begin
                     com_cnt_s = cnt_inc_s[3:0];
                  end
               end else begin
                  com_cnt_s = 4'd0;
               end
            end
            ACTIVE: begin
               if (is_com_s) begin
                  // A COM mid-group is itself the first COM of the relock run.
                  if (lane_ptr != 2'd0) begin
                     misalign_s = 1'b1;
                     state_s    = ALIGN;
                     com_cnt_s  = 4'd1;
                  end else begin
                     state_s = ACTIVE;
                  end
               end else begin
                  accept_s = 1'b1;
               end
            end
            default: begin
               state_s   = ALIGN;
               com_cnt_s = 4'd0;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   assign aligned  = (state_r == ACTIVE);
   assign misalign = misalign_s;
   assign accept   = accept_s;

endmodule

// File: rtl/phy_rx_demux.sv
// Receive lane demultiplexer: regroups the aligned byte stream into 4-byte
// lane groups. Optional misalignment counter enabled by PHY_RX_ERRCNT_EN.
module phy_rx_demux
   import phy_pkg::*;
#(
   parameter logic [7:0] COM_SYMBOL  = COM_SYMBOL_DEF,
   parameter int         ALIGN_COUNT = ALIGN_COUNT_DEF
) (
   input  logic           clk,
   input  logic           reset,
   phy_rx_demux_if.slave  bus
);

   logic [LANE_PTR_W-1:0] lane_ptr_r;
   logic [7:0]            group_r [0:NUM_LANES-1];
   logic [7:0]            dout_r  [0:NUM_LANES-1];
   logic                  vout_r;
   logic                  aligned_s;
   logic                  misalign_s;
   logic                  accept_s;

   phy_rx_aligner #(
      .COM_SYMBOL  (COM_SYMBOL),
      .ALIGN_COUNT (ALIGN_COUNT)
   ) u_aligner (
      .clk      (clk),
      .reset    (reset),
      .data_in  (bus.data_in),
      .valid_in (bus.valid_in),
      .lane_ptr (lane_ptr_r),
      .aligned  (aligned_s),
      .misalign (misalign_s),
      .accept   (accept_s)
   );

   // Lane pointer, partial group storage and registered lane outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane_ptr_r <= 2'd0;
         vout_r     <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) begin
            group_r[i] <= 8'h00;
            dout_r[i]  <= 8'h00;
         end
      end else begin
         vout_r <= 1'b0;
         if (misalign_s) begin
            lane_ptr_r <= 2'd0;
         end else if (accept_s) begin
            lane_ptr_r          <= lane_ptr_r + 2'd1;
            group_r[lane_ptr_r] <= bus.data_in;
            // The last lane bypasses storage so the group lands in one edge.
            if (lane_ptr_r == 2'd3) begin
               dout_r[0] <= group_r[0];
               dout_r[1] <= group_r[1];
               dout_r[2] <= group_r[2];
               dout_r[3] <= bus.data_in;
               vout_r    <= 1'b1;
            end else begin
               vout_r <= 1'b0;
            end
         end else begin
            lane_ptr_r <= lane_ptr_r;
         end
      end
   end

   assign bus.data_out0  = dout_r[0];
   assign bus.data_out1  = dout_r[1];
   assign bus.data_out2  = dout_r[2];
   assign bus.data_out3  = dout_r[3];
   assign bus.valid_out0 = vout_r;
   assign bus.valid_out1 = vout_r;
   assign bus.valid_out2 = vout_r;
   assign bus.valid_out3 = vout_r;
   assign bus.aligned    = aligned_s;

`ifdef PHY_RX_ERRCNT_EN
   logic [7:0] err_r;

   // Misalignment event counter, saturating, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_r <= 8'h00;
      end else if (misalign_s) begin
         err_r <= sat_inc8(err_r);
      end else begin
         err_r <= err_r;
      end
   end

   assign bus.err_count = err_r;
`endif

endmodule
